// File: rtl/microwave_timer.sv
// microwave_timer
// ---------------
// MM:SS countdown timer for a microwave oven. Digits are entered from a keypad
// (shifted in from the right), counted down once per second while running, and
// presented as four registered BCD digits, one per downstream 7-segment driver.
//
// Parameters:
//   TICKS_PER_SEC  clk cycles per countdown second
//   CNT_W          prescaler width, 2**CNT_W must exceed TICKS_PER_SEC
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   key_valid    one-cycle strobe, key_digit carries a new keypad entry
//   key_digit    BCD keypad digit, 10..15 ignored
//   start        one-cycle start / resume command
//   stop         one-cycle pause / cancel command
//   clear        one-cycle clear of the entered time
//   door_closed  level, 1 = door closed
//   min_tens     BCD minutes tens digit
//   min_ones     BCD minutes ones digit
//   sec_tens     BCD seconds tens digit
//   sec_ones     BCD seconds ones digit
//   mag_on       magnetron enable, high only while running
//   done         one-cycle pulse when the count reaches 00:00

`timescale 1ns/1ps

module microwave_timer #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned CNT_W         = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       door_closed,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       mag_on,
  output logic       done
);

  typedef enum logic [1:0] {
    StIdle,
    StRunning,
    StPaused,
    StDone
  } state_e;

  localparam logic [CNT_W-1:0] PrescLast = CNT_W'(TICKS_PER_SEC - 1);

  state_e           state;
  logic [CNT_W-1:0] presc;

  // Decremented digits (one second less than the current display).
  logic [3:0] dec_min_tens;
  logic [3:0] dec_min_ones;
  logic [3:0] dec_sec_tens;
  logic [3:0] dec_sec_ones;
  logic       dec_zero;
  logic       digits_zero;
  logic       tick;
  logic       key_ok;
  logic       can_start;
  logic       any_cmd;

  // BCD borrow chain. Seconds entered above 59 simply count down through the
  // tens digit; the borrow only reloads sec_tens with 5 when it is already 0.
  always_comb begin
    dec_min_tens = min_tens;
    dec_min_ones = min_ones;
    dec_sec_tens = sec_tens;
    dec_sec_ones = sec_ones;
    if (sec_ones != 4'd0) begin
      dec_sec_ones = sec_ones - 4'd1;
    end else begin
      dec_sec_ones = 4'd9;
      if (sec_tens != 4'd0) begin
        dec_sec_tens = sec_tens - 4'd1;
      end else begin
        dec_sec_tens = 4'd5;
        if (min_ones != 4'd0) begin
          dec_min_ones = min_ones - 4'd1;
        end else begin
          dec_min_ones = 4'd9;
          dec_min_tens = min_tens - 4'd1;
        end
      end
    end
  end

  always_comb begin
    dec_zero    = (dec_min_tens == 4'd0) && (dec_min_ones == 4'd0) &&
                  (dec_sec_tens == 4'd0) && (dec_sec_ones == 4'd0);
    digits_zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                  (sec_tens == 4'd0) && (sec_ones == 4'd0);
    tick        = (presc == PrescLast);
    key_ok      = key_valid && (key_digit <= 4'd9);
    // stop always wins over start.
    can_start   = start && !stop && door_closed;
    any_cmd     = key_valid || start || stop || clear;
  end

  // Single state machine; every output is a register written here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= StIdle;
      presc    <= '0;
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      mag_on   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (can_start && !digits_zero) begin
            state  <= StRunning;
            presc  <= '0;
            mag_on <= 1'b1;
          end else if (clear) begin
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
          end else if (key_ok) begin
            min_tens <= min_ones;
            min_ones <= sec_tens;
            sec_tens <= sec_ones;
            sec_ones <= key_digit;
          end
        end

        StRunning: begin
          if (stop || !door_closed) begin
            // Pausing swallows a tick landing in this cycle; presc is held.
            state  <= StPaused;
            mag_on <= 1'b0;
          end else if (tick) begin
            presc    <= '0;
            min_tens <= dec_min_tens;
            min_ones <= dec_min_ones;
            sec_tens <= dec_sec_tens;
            sec_ones <= dec_sec_ones;
            if (dec_zero) begin
              state  <= StDone;
              mag_on <= 1'b0;
              done   <= 1'b1;
            end
          end else begin
            presc <= presc + CNT_W'(1);
          end
        end

        StPaused: begin
          if (stop) begin
            state    <= StIdle;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
          end else if (start && door_closed) begin
            // Resume from the held prescaler phase.
            state  <= StRunning;
            mag_on <= 1'b1;
          end
        end

        StDone: begin
          // The command that leaves DONE is consumed, not acted on.
          if (any_cmd) begin
            state    <= StIdle;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
          end
        end

        default: begin
          state  <= StIdle;
          mag_on <= 1'b0;
        end
      endcase
    end
  end

endmodule
